// File: rtl/pmc_dc_bank_pkg.sv
// pmc_dc_bank shared types and register map helpers.
// Shared by the decoder and the bank top.
package pmc_dc_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_LOCK   = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_PEND = 1;
  localparam int unsigned STAT_LOCK = 2;
  localparam int unsigned STAT_CNT  = 8;

  typedef struct packed {
    logic [7:0] cnt;
    logic       locked;
    logic       pending;
    logic       busy;
  } status_t;

  function automatic int ctrl_off(input int n);
    return n;
  endfunction

  function automatic int status_off(input int n);
    return n + 1;
  endfunction

  function automatic int active_off(input int n);
    return n + 2;
  endfunction

  function automatic int end_off(input int n);
    return 2 * n + 2;
  endfunction

  function automatic logic [31:0] status_word(
    input status_t s
  );
    logic [31:0] w;
    w = '0;
    w[STAT_BUSY] = s.busy;
    w[STAT_PEND] = s.pending;
    w[STAT_LOCK] = s.locked;
    w[STAT_CNT +: 8] = s.cnt;
    return w;
  endfunction

endpackage

// File: rtl/ibex_data_bus.sv
// Ibex-style data bus: req/gnt, one-cycle rvalid.
// Slave side is the peripheral register bank.
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic        err;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/pmc_dc_bank_decoder.sv
// Register-class decode for the PM config bank.
// Also owns gnt and the registered rvalid/err.
module pmc_dc_bank_decoder
  import pmc_dc_bank_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] off,
  input  logic       req,
  input  logic       we,
  input  logic       locked,
  input  logic       commit_bit,
  output logic       sh_hit,
  output logic       ctrl_hit,
  output logic       stat_hit,
  output logic       act_hit,
  output logic       invalid,
  output logic [3:0] sh_idx,
  output logic [3:0] act_idx,
  output logic       gnt,
  output logic       rvalid,
  output logic       err
);

  int   o;
  logic acc_err;

  assign o        = {28'd0, off};
  assign sh_hit   = o < NUM_CH;
  assign ctrl_hit = o == ctrl_off(NUM_CH);
  assign stat_hit = o == status_off(NUM_CH);
  assign act_hit  = (o >= active_off(NUM_CH))
                 && (o < end_off(NUM_CH));
  assign invalid  = !(sh_hit | ctrl_hit
                    | stat_hit | act_hit);
  assign sh_idx   = off;
  assign act_idx  = 4'(o - active_off(NUM_CH));
  assign gnt      = req;

  // Unmapped, RO writes, and locked shadow/commit writes fault
  assign acc_err = invalid
                 | (we & (stat_hit | act_hit))
                 | (we & locked & (sh_hit
                   | (ctrl_hit & commit_bit)));

  // Response one cycle after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= req;
      err    <= req & acc_err;
    end
  end

endmodule

// File: rtl/pmc_dc_bank.sv
// Multi-channel PM config bank with atomic commit.
// Shadow words copy to cfg_active, then a settle hold.
module pmc_dc_bank
  import pmc_dc_bank_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CFG_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ibex_data_bus.slave                  data_bus,
  output logic [NUM_CH-1:0][CFG_W-1:0] cfg_active,
  output logic                         cfg_update,
  output logic                         cfg_busy
);

  localparam logic [7:0] SETTLE_LAST =
    8'(SETTLE_CYCLES - 1);

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  off;
  logic        unused_addr;

  assign req   = data_bus.req;
  assign we    = data_bus.we;
  assign be    = data_bus.be;
  assign wdata = data_bus.wdata;
  assign off   = data_bus.addr[5:2];
  assign unused_addr = ^{data_bus.addr[31:6],
                         data_bus.addr[1:0]};

  logic       sh_hit;
  logic       ctrl_hit;
  logic       stat_hit;
  logic       act_hit;
  logic       invalid;
  logic [3:0] sh_idx;
  logic [3:0] act_idx;
  logic       commit_bit;
  logic       lock_bit;
  logic       locked;

  assign commit_bit = be[0] & wdata[CTRL_COMMIT];
  assign lock_bit   = be[0] & wdata[CTRL_LOCK];

  pmc_dc_bank_decoder #(
    .NUM_CH(NUM_CH)
  ) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .off       (off),
    .req       (req),
    .we        (we),
    .locked    (locked),
    .commit_bit(commit_bit),
    .sh_hit    (sh_hit),
    .ctrl_hit  (ctrl_hit),
    .stat_hit  (stat_hit),
    .act_hit   (act_hit),
    .invalid   (invalid),
    .sh_idx    (sh_idx),
    .act_idx   (act_idx),
    .gnt       (data_bus.gnt),
    .rvalid    (data_bus.rvalid),
    .err       (data_bus.err)
  );

  logic        wr;
  logic        commit_req;
  logic        lock_set;
  logic        sh_wr;
  logic [31:0] bmask;

  assign wr         = req & we;
  assign commit_req = wr & ctrl_hit & commit_bit
                    & ~locked;
  assign lock_set   = wr & ctrl_hit & lock_bit;
  assign sh_wr      = wr & sh_hit & ~locked;
  assign bmask      = {{8{be[3]}}, {8{be[2]}},
                       {8{be[1]}}, {8{be[0]}}};

  function automatic logic [CFG_W-1:0] merge(
    input logic [CFG_W-1:0] old,
    input logic [31:0]      d,
    input logic [31:0]      m
  );
    logic [31:0] w;
    w = (32'(old) & ~m) | (d & m);
    return w[CFG_W-1:0];
  endfunction

  logic [NUM_CH-1:0][CFG_W-1:0] shadow;

  // Shadow byte writes and the sticky lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      locked <= 1'b0;
    end else begin
      if (lock_set) locked <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sh_wr && sh_idx == 4'(i)) begin
          shadow[i] <= merge(shadow[i], wdata, bmask);
        end
      end
    end
  end

  state_e     state;
  logic [7:0] settle_cnt;
  logic [7:0] commit_cnt;
  logic       pending;

  // Commit FSM: apply, settle, absorb one queued commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      commit_cnt <= '0;
      pending    <= 1'b0;
      cfg_active <= '0;
      cfg_update <= 1'b0;
      cfg_busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit_req || pending) begin
            state      <= ST_APPLY;
            cfg_update <= 1'b1;
            cfg_busy   <= 1'b1;
          end
        end
        ST_APPLY: begin
          cfg_active <= shadow;
          cfg_update <= 1'b0;
          commit_cnt <= commit_cnt + 8'd1;
          pending    <= commit_req;
          settle_cnt <= SETTLE_LAST;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          pending <= pending | commit_req;
          if (settle_cnt == 8'd0) begin
            if (pending || commit_req) begin
              state      <= ST_APPLY;
              cfg_update <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              cfg_busy <= 1'b0;
            end
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cfg_update <= 1'b0;
          cfg_busy   <= 1'b0;
        end
      endcase
    end
  end

  status_t     st;
  logic [31:0] rd_word;

  assign st = '{cnt:     commit_cnt,
                locked:  locked,
                pending: pending,
                busy:    cfg_busy};

  // Readout mux over all register classes
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sh_hit && sh_idx == 4'(i)) begin
        rd_word = 32'(shadow[i]);
      end
      if (act_hit && act_idx == 4'(i)) begin
        rd_word = 32'(cfg_active[i]);
      end
    end
    if (ctrl_hit) rd_word[CTRL_LOCK] = locked;
    if (stat_hit) rd_word = status_word(st);
    if (invalid)  rd_word = '0;
  end

  // Read data captured at the grant cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_bus.rdata <= '0;
    end else begin
      data_bus.rdata <= (req && !we) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_pmc_dc_bank.sv
// Self-checking bench for pmc_dc_bank.
// Vector table, hand sequences and random traffic.
module tb_pmc_dc_bank;

  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int S    = 8;
  localparam int CTRL = NCH;
  localparam int STAT = NCH + 1;
  localparam int ACT0 = NCH + 2;
  localparam int BAD  = 2 * NCH + 2;
  localparam logic [31:0] MASK = 32'((64'd1 << W) - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_data_bus bus();
  logic [NCH-1:0][W-1:0] cfg_active;
  logic                  cfg_update;
  logic                  cfg_busy;

  pmc_dc_bank #(
    .NUM_CH(NCH),
    .CFG_W(W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_bus  (bus),
    .cfg_active(cfg_active),
    .cfg_update(cfg_update),
    .cfg_busy  (cfg_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h",
               nm, act, exp);
    end
  endtask

  // Reference model: commits are scheduled as apply times
  typedef struct {
    int a;
    bit q;
    int rc;
  } ap_t;

  int          c;
  logic [31:0] m_sh[NCH];
  logic [31:0] m_act[NCH];
  bit          m_lock;
  int          m_cnt;
  ap_t         ap[$];
  int          last_end;
  bit          p_req;
  bit          p_err;
  logic [31:0] p_rd;

  function automatic bit m_busy(input int t);
    foreach (ap[k])
      if (ap[k].a <= t && t <= ap[k].a + S) return 1;
    return 0;
  endfunction

  function automatic bit m_apply(input int t);
    foreach (ap[k]) if (ap[k].a == t) return 1;
    return 0;
  endfunction

  function automatic bit m_pend(input int t);
    foreach (ap[k])
      if (ap[k].q && ap[k].rc < t && t <= ap[k].a)
        return 1;
    return 0;
  endfunction

  function automatic bit m_queued_after(input int t);
    foreach (ap[k]) if (ap[k].a > t) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int off);
    logic [7:0] cn;
    cn = 8'(m_cnt);
    if (off < NCH) return m_sh[off];
    if (off == CTRL) return {30'd0, m_lock, 1'b0};
    if (off == STAT)
      return {16'd0, cn, 5'd0, m_lock,
              m_pend(c), m_busy(c)};
    if (off >= ACT0 && off < BAD) return m_act[off-ACT0];
    return 32'd0;
  endfunction

  function automatic bit m_errf(input bit we,
                                input int off,
                                input logic [3:0] be,
                                input logic [31:0] wd);
    if (off >= BAD) return 1;
    if (we && (off == STAT || off >= ACT0)) return 1;
    if (we && m_lock &&
        (off < NCH || (off == CTRL && be[0] && wd[0])))
      return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_lock   = 0;
    m_cnt    = 0;
    ap.delete();
    last_end = -100;
    p_req    = 0;
    p_err    = 0;
    p_rd     = '0;
  endtask

  task automatic chk_outputs();
    chk("rvalid", 32'(bus.rvalid), 32'(p_req));
    if (p_req) begin
      chk("err", 32'(bus.err), 32'(p_err));
      chk("rdata", bus.rdata, p_rd);
    end
    chk("cfg_update", 32'(cfg_update), 32'(m_apply(c)));
    chk("cfg_busy", 32'(cfg_busy), 32'(m_busy(c)));
    for (int i = 0; i < NCH; i++)
      chk($sformatf("cfg_active[%0d]", i),
          32'(cfg_active[i]), m_act[i]);
  endtask

  // One bus cycle; called and returns at a negedge
  task automatic cycle(input bit rq, input bit we,
                       input int off,
                       input logic [3:0] be,
                       input logic [31:0] wd,
                       output logic [31:0] rd,
                       output bit er);
    logic [31:0] v;
    bus.req   = rq;
    bus.we    = we;
    bus.addr  = {26'd0, off[3:0], 2'b00};
    bus.be    = be;
    bus.wdata = wd;
    #1;
    chk("gnt", 32'(bus.gnt), 32'(rq));
    p_req = rq;
    p_rd  = (rq && !we) ? m_read(off) : 32'd0;
    p_err = rq && m_errf(we, off, be, wd);
    if (m_apply(c)) begin
      for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
      m_cnt = (m_cnt + 1) % 256;
    end
    if (rq && we && off == CTRL && be[0] && wd[0]
        && !m_lock) begin
      if (!m_busy(c)) begin
        ap.push_back('{c + 1, 0, c});
        last_end = c + 1 + S;
      end else if (!m_queued_after(c)) begin
        ap.push_back('{last_end + 1, 1, c});
        last_end = last_end + 1 + S;
      end
    end
    if (rq && we && off < NCH && !m_lock) begin
      v = m_sh[off];
      for (int b = 0; b < 4; b++)
        if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
      m_sh[off] = v & MASK;
    end
    if (rq && we && off == CTRL && be[0] && wd[1])
      m_lock = 1;
    @(posedge clk);
    c++;
    @(negedge clk);
    chk_outputs();
    rd = bus.rdata;
    er = bus.err;
    bus.req = 1'b0;
  endtask

  logic [31:0] rd;
  bit          er;

  task automatic idle(input int n);
    logic [31:0] d;
    bit          e;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'h0, 0, d, e);
  endtask

  task automatic wr_reg(input int off, input logic [31:0] d);
    cycle(1, 1, off, 4'hF, d, rd, er);
  endtask

  task automatic rd_reg(input int off);
    cycle(1, 0, off, 4'hF, 32'd0, rd, er);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(cfg_busy), 32'd0);
    chk({tag, "_update"}, 32'(cfg_update), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_active"}, 32'(cfg_active[0])
        | 32'(cfg_active[1]) | 32'(cfg_active[2])
        | 32'(cfg_active[3]), 32'd0);
  endtask

  typedef struct {
    bit          we;
    int          off;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t tv[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.be    = '0;
    bus.wdata = '0;
    c = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int o = 0; o < 16; o++)
      tv.push_back('{0, o, 4'hF, 32'd0, 32'd0, o >= BAD});
    tv.push_back('{1, 1, 4'b0001, 32'h0000A5A5, 0, 0});
    tv.push_back('{0, 1, 4'hF, 0, 32'h000000A5, 0});
    tv.push_back('{1, 2, 4'hF, 32'hFFFFFFFF, 0, 0});
    tv.push_back('{0, 2, 4'hF, 0, 32'h0000FFFF, 0});
    tv.push_back('{1, 3, 4'b0010, 32'h12345678, 0, 0});
    tv.push_back('{0, 3, 4'hF, 0, 32'h00005600, 0});
    tv.push_back('{1, ACT0, 4'hF, 32'd1, 0, 1});
    tv.push_back('{1, STAT, 4'hF, 32'd1, 0, 1});
    tv.push_back('{1, BAD, 4'hF, 32'd1, 0, 1});
    tv.push_back('{0, ACT0 + 1, 4'hF, 0, 32'd0, 0});
    tv.push_back('{0, CTRL, 4'hF, 0, 32'd0, 0});
    foreach (tv[k]) begin
      cycle(1, tv[k].we, tv[k].off, tv[k].be,
            tv[k].wd, rd, er);
      chk($sformatf("tbl%0d_rdata", k), rd, tv[k].rd);
      chk($sformatf("tbl%0d_err", k), 32'(er),
          32'(tv[k].er));
    end

    // Single commit
    wr_reg(CTRL, 32'd1);
    chk("commit_update_n1", 32'(cfg_update), 32'd1);
    chk("commit_busy_n1", 32'(cfg_busy), 32'd1);
    idle(1);
    chk("commit_active1", 32'(cfg_active[1]), 32'h00A5);
    idle(S + 1);
    rd_reg(STAT);
    chk("commit_status", rd, 32'h00000100);

    // Queued commit takes the latest shadow
    wr_reg(CTRL, 32'd1);
    idle(2);
    wr_reg(CTRL, 32'd1);
    wr_reg(1, 32'h00001234);
    wr_reg(CTRL, 32'd1);
    rd_reg(STAT);
    chk("queue_status_pend", rd & 32'h3, 32'h3);
    idle(2 * S + 4);
    chk("queue_active1", 32'(cfg_active[1]), 32'h1234);
    rd_reg(STAT);
    chk("queue_status", rd, 32'h00000300);

    // Random traffic, lock bit kept clear
    for (int i = 0; i < 600; i++) begin
      bit          rq;
      bit          we;
      int          off;
      logic [31:0] wd;
      rq  = $urandom_range(0, 9) < 7;
      we  = 1'($urandom_range(0, 1));
      off = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) off = CTRL;
      wd  = $urandom;
      if (off == CTRL) wd[1] = 1'b0;
      cycle(rq, we, off, 4'($urandom), wd, rd, er);
    end
    idle(2 * S + 4);

    // Reset mid-settle with a commit queued
    wr_reg(CTRL, 32'd1);
    idle(3);
    wr_reg(CTRL, 32'd1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    c++;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    idle(S + 4);

    // commit_cnt wraps after 256 applies
    for (int k = 0; k < 256; k++) begin
      wr_reg(CTRL, 32'd1);
      idle(S + 1);
    end
    rd_reg(STAT);
    chk("wrap_cnt", rd, 32'h00000000);

    // Lock behaviour
    wr_reg(0, 32'h00001111);
    wr_reg(CTRL, 32'd1);
    idle(S + 2);
    wr_reg(CTRL, 32'd2);
    chk("lock_set_err", 32'(er), 32'd0);
    wr_reg(0, 32'h00002222);
    chk("lock_shadow_err", 32'(er), 32'd1);
    wr_reg(CTRL, 32'd1);
    chk("lock_commit_err", 32'(er), 32'd1);
    chk("lock_no_update", 32'(cfg_update), 32'd0);
    wr_reg(CTRL, 32'd2);
    chk("lock_rewrite_err", 32'(er), 32'd0);
    rd_reg(0);
    chk("lock_shadow_kept", rd, 32'h00001111);
    rd_reg(STAT);
    chk("lock_status", rd, 32'h00000104);
    rd_reg(CTRL);
    chk("lock_ctrl_read", rd, 32'h00000002);
    chk("lock_active0", 32'(cfg_active[0]), 32'h1111);

    // Unmapped and read-only accesses
    rd_reg(BAD);
    chk("bad_rd_err", 32'(er), 32'd1);
    chk("bad_rd_rvalid", 32'(bus.rvalid), 32'd1);
    wr_reg(ACT0, 32'hFFFF);
    chk("act_wr_err", 32'(er), 32'd1);
    rd_reg(ACT0);
    chk("act_unchanged", rd, 32'h00001111);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
